serial_addsub_demux: RTL and testbench
======================================

# serial_addsub_demux

Parametrised bit-serial adder/subtractor for WIDTH-bit operands. Its per-bit arithmetic cell is a demultiplexer-based full adder / full subtractor, the multi-bit sequential successor to the team's demux-based half adder. It accepts an operand pair on a start strobe and processes one bit per clock, LSB first. It then presents result, carry/borrow and signed overflow with a one-cycle done pulse. It sits beside the combinational demux arithmetic cells as the area-minimal multi-bit datapath option.

## Interface
- WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; sampled only when ready.
- mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
- a  input  WIDTH  first operand; sampled with start.
- b  input  WIDTH  second operand; sampled with start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  output  1  carry out (add) or borrow out (sub).
- ovf  output  1  two's-complement signed overflow.

## Operation
- FSM states:
  - IDLE: the only state after reset.
  - RUN: one bit is processed per cycle.
  - DONE: lasts one cycle.
- IDLE or DONE with start=1: capture a, b and mode into internal shift registers. Clear the carry/borrow register c to 0 and the bit counter to 0, then go to RUN.
- IDLE or DONE with start=0: go to / stay in IDLE.
- RUN, each cycle:
  - Apply select {a_i, b_i, c} to a 1x8 demux with its data input tied to 1.
  - s_i = OR of demux outputs 1, 2, 4, 7. This is the same for add and subtract.
  - Add carry = OR of outputs 3, 5, 6, 7.
  - Sub borrow = OR of outputs 1, 2, 3, 7.
  - s_i shifts into the MSB of the internal result shift register. Operand registers shift right. c takes the new carry/borrow. The counter increments.
- The counter is $clog2(WIDTH) + 1 bits wide and wraps to 0 on completion.
- RUN, counter = WIDTH-1 (last bit):
  - Load the output registers: result = the completed shift value, cout = the final carry/borrow.
  - ovf = (carry/borrow into MSB) XOR (carry/borrow out of MSB).
  - Go to DONE.
- result, cout and ovf change only at that completion edge and at reset. They hold through IDLE and through any subsequent RUN until the next completion.
- busy = (state == RUN). done = (state == DONE).
- start while in RUN is ignored: no capture and no error.
- start in DONE is accepted, giving back-to-back operation with no idle cycle.
- Operand and mode input changes after the capture edge have no effect.

## Timing
- Reset (asynchronous assert):
  - state IDLE, busy 0, done 0, result 0, cout 0, ovf 0.
  - Internal registers and counter are 0.
- Reset asserted mid-RUN aborts the operation: no done pulse, and outputs read 0.
- Release of rst is synchronous to clk. The first start is accepted at the first rising edge with rst low.
- Start accepted at edge E0:
  - busy is high from E0 to EWIDTH.
  - Bit i is processed at edge E(i+1).
  - Outputs are updated at EWIDTH. done is high from EWIDTH to EWIDTH+1.
- Latency is WIDTH+1 cycles from the start edge to the done deassertion.
- Throughput is one operation per WIDTH+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Add, WIDTH=8: a=8'h3C, b=8'h0F, mode=0 -> result 8'h4B, cout 0, ovf 0. busy high for exactly 8 cycles; done high exactly 8 edges after the start edge, for 1 cycle.
- Add edge cases:
  - 8'hFF + 8'h01 -> result 8'h00, cout 1, ovf 0.
  - 8'h7F + 8'h01 -> result 8'h80, cout 0, ovf 1.
- Subtract cases:
  - 8'h05 - 8'h07 -> result 8'hFE, cout (borrow) 1, ovf 0.
  - 8'h80 - 8'h01 -> result 8'h7F, cout 0, ovf 1.
  - 8'h00 - 8'h00 -> result 8'h00, cout 0, ovf 0.
- Control:
  - Pulse start with new operands in RUN cycle 3 -> ignored; the original result is delivered.
  - Hold start high through DONE -> the next operation begins immediately, and done pulses again 8 edges later.
  - Outputs stay stable between operations.
- Reset: assert rst during RUN cycle 4 -> busy, done, result, cout and ovf go to 0 immediately (asynchronously). No done pulse occurs. A fresh start after release completes correctly.
- Exhaustive sweep, WIDTH=4: all 256 operand pairs x both modes, checked against a behavioural model for result, cout and ovf. Repeat the same sweep at WIDTH=2.

Source files
------------

// File: rtl/serial_addsub_demux.sv
// serial_addsub_demux: bit-serial WIDTH-bit add/subtract, LSB first, with a demux-based full adder/subtractor cell.
// Latency: WIDTH+1 cycles from the start edge to the fall of done. busy is high for WIDTH cycles, then done pulses for 1 cycle.
// Backpressure: none. start is taken only in IDLE/DONE and is ignored while busy, so back-to-back starts from DONE lose no cycle.
// Ports:
//   clk, rst (async active-high); start, mode (0 add, 1 sub), a, b sampled together when idle/done;
//   busy, done, result, cout (carry or borrow), ovf (signed overflow); all of them registered.
module serial_addsub_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             c;
  logic             mode_r;
  logic [CW-1:0]    cnt;

  logic [2:0]       sel;
  logic [7:0]       dmx;
  logic             s_bit;
  logic             c_next;
  logic             last;
  logic [WIDTH-1:0] sr_next;

  // The 1x8 demux has its data input tied to 1, so exactly one output goes high: the one that sel picks.
  // Sum and carry/borrow are each an OR of a fixed set of minterms.
  always_comb begin
    sel     = {sa[0], sb[0], c};
    dmx     = 8'b0000_0001 << sel;
    s_bit   = dmx[1] | dmx[2] | dmx[4] | dmx[7];
    c_next  = mode_r ? (dmx[1] | dmx[2] | dmx[3] | dmx[7])
                     : (dmx[3] | dmx[5] | dmx[6] | dmx[7]);
    last    = (cnt == CW'(WIDTH - 1));
    sr_next = {s_bit, sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      c      <= 1'b0;
      mode_r <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            mode_r <= mode;
            c      <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          sr <= sr_next;
          sa <= sa >> 1;
          sb <= sb >> 1;
          c  <= c_next;
          if (last) begin
            // c still holds the carry/borrow into the MSB; c_next is the carry/borrow out of the MSB.
            result <= sr_next;
            cout   <= c_next;
            ovf    <= c ^ c_next;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_demux.sv
module tb_serial_addsub_demux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       s8, m8, busy8, done8, co8, ov8;
  logic [7:0] a8, b8, r8;
  logic       s4, m4, busy4, done4, co4, ov4;
  logic [3:0] a4, b4, r4;
  logic       s2, m2, busy2, done2, co2, ov2;
  logic [1:0] a2, b2, r2;

  serial_addsub_demux #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .mode(m8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(r8), .cout(co8), .ovf(ov8));
  serial_addsub_demux #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4), .mode(m4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(r4), .cout(co4), .ovf(ov4));
  serial_addsub_demux #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(s2), .mode(m2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .result(r2), .cout(co2), .ovf(ov2));

  // Reference model built from plain integer arithmetic: returns {ovf, cout, result[7:0]}.
  function automatic logic [9:0] model(int w, bit sub, int a, int b);
    int mask, msb, r, co, ov;
    mask = (1 << w) - 1;
    msb  = 1 << (w - 1);
    if (!sub) begin
      r  = (a + b) & mask;
      co = ((a + b) >> w) & 1;
      ov = (((a ^ r) & (b ^ r) & msb) != 0) ? 1 : 0;
    end else begin
      r  = (a - b) & mask;
      co = (a < b) ? 1 : 0;
      ov = (((a ^ b) & (a ^ r) & msb) != 0) ? 1 : 0;
    end
    return {ov[0], co[0], r[7:0]};
  endfunction

  // Presents one operation to the 8-bit instance and returns just after the capture edge.
  task automatic go8(input bit m, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    s8 = 1'b1; m8 = m; a8 = a; b8 = b;
    @(negedge clk);
    s8 = 1'b0;
  endtask

  // Counts busy cycles (bounded) and reports whether done failed to show up.
  task automatic wait8(output int n, output bit to);
    n = 0;
    while (busy8 === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    to = (done8 !== 1'b1);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy8, done8, co8, ov8, r8} !== 12'h000) begin
      errors++;
      $display("FAIL reset_w8: got busy=%b done=%b res=%h cout=%b ovf=%b, expected all 0", busy8, done8, r8, co8, ov8);
    end
    checks++;
    if ({busy4, done4, co4, ov4, r4, busy2, done2, co2, ov2, r2} !== 14'h0) begin
      errors++;
      $display("FAIL reset_w4w2: got w4 %b%b%b%b %h, w2 %b%b%b%b %h, expected all 0",
               busy4, done4, co4, ov4, r4, busy2, done2, co2, ov2, r2);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_basic();
    int n; bit to;
    go8(1'b0, 8'h3C, 8'h0F);
    wait8(n, to);
    checks++;
    if (n != 8 || to) begin
      errors++;
      $display("FAIL add_basic_timing: busy cycles %0d timeout %b, expected 8 busy cycles then done", n, to);
    end
    checks++;
    if ({ov8, co8, r8} !== {1'b0, 1'b0, 8'h4B}) begin
      errors++;
      $display("FAIL add_basic_value: got res=%h cout=%b ovf=%b, expected 4b 0 0", r8, co8, ov8);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL add_basic_pulse: done=%b busy=%b one cycle after done, expected 0 0", done8, busy8);
    end
    a8 = 8'hAA; b8 = 8'h55; m8 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ov8, co8, r8} !== {1'b0, 1'b0, 8'h4B} || done8 !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got res=%h cout=%b ovf=%b done=%b, expected 4b 0 0 0", r8, co8, ov8, done8);
    end
  endtask

  task automatic test_edge_cases();
    bit         em[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] ea[5] = '{8'hFF, 8'h7F, 8'h05, 8'h80, 8'h00};
    logic [7:0] eb[5] = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h00};
    logic [7:0] er[5] = '{8'h00, 8'h80, 8'hFE, 8'h7F, 8'h00};
    bit         ec[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bit         eo[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int n; bit to;
    for (int i = 0; i < 5; i++) begin
      go8(em[i], ea[i], eb[i]);
      wait8(n, to);
      checks++;
      if (to || {ov8, co8, r8} !== {eo[i], ec[i], er[i]}) begin
        errors++;
        $display("FAIL edge_case_%0d: mode %b %h,%h got res=%h cout=%b ovf=%b timeout=%b, expected %h %b %b",
                 i, em[i], ea[i], eb[i], r8, co8, ov8, to, er[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_random8();
    int n; bit to; bit m; logic [7:0] a, b; logic [9:0] e;
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      e = model(8, m, int'(a), int'(b));
      go8(m, a, b);
      wait8(n, to);
      checks++;
      if (to || n != 8 || {ov8, co8, r8} !== e) begin
        errors++;
        $display("FAIL random8_%0d: mode %b %h,%h got res=%h cout=%b ovf=%b busy=%0d timeout=%b, expected %h %b %b busy=8",
                 i, m, a, b, r8, co8, ov8, n, to, e[7:0], e[8], e[9]);
      end
    end
  endtask

  task automatic test_start_in_run();
    int n; bit to; logic [9:0] e;
    e = model(8, 1'b0, 8'h91, 8'h23);
    go8(1'b0, 8'h91, 8'h23);
    repeat (2) @(negedge clk);
    s8 = 1'b1; m8 = 1'b1; a8 = 8'h10; b8 = 8'h77;
    @(negedge clk);
    s8 = 1'b0;
    wait8(n, to);
    checks++;
    if (to || {ov8, co8, r8} !== e) begin
      errors++;
      $display("FAIL start_in_run: got res=%h cout=%b ovf=%b timeout=%b, expected %h %b %b", r8, co8, ov8, to, e[7:0], e[8], e[9]);
    end
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run_idle: busy=%b done=%b after done, expected 0 0", busy8, done8);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit to; logic [9:0] e1, e2;
    e1 = model(8, 1'b1, 8'h12, 8'h34);
    e2 = model(8, 1'b0, 8'hC8, 8'h64);
    @(negedge clk);
    s8 = 1'b1; m8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    @(negedge clk);
    m8 = 1'b0; a8 = 8'hC8; b8 = 8'h64;
    wait8(n, to);
    checks++;
    if (to || n != 8 || {ov8, co8, r8} !== e1) begin
      errors++;
      $display("FAIL b2b_first: got res=%h cout=%b ovf=%b busy=%0d timeout=%b, expected %h %b %b busy=8",
               r8, co8, ov8, n, to, e1[7:0], e1[8], e1[9]);
    end
    @(negedge clk);
    s8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b done=%b right after done, expected 1 0", busy8, done8);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({ov8, co8, r8} !== e1) begin
      errors++;
      $display("FAIL hold_during_run: got res=%h cout=%b ovf=%b, expected %h %b %b", r8, co8, ov8, e1[7:0], e1[8], e1[9]);
    end
    wait8(n, to);
    checks++;
    if (to || n != 5 || {ov8, co8, r8} !== e2) begin
      errors++;
      $display("FAIL b2b_second: got res=%h cout=%b ovf=%b remaining busy=%0d timeout=%b, expected %h %b %b remaining busy=5",
               r8, co8, ov8, n, to, e2[7:0], e2[8], e2[9]);
    end
  endtask

  task automatic test_reset_mid_run();
    int n; bit to; bit seen; logic [9:0] e;
    go8(1'b0, 8'h5A, 8'h3B);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, co8, ov8, r8} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_run: got busy=%b done=%b res=%h cout=%b ovf=%b, expected all 0", busy8, done8, r8, co8, ov8);
    end
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done8 === 1'b1) seen = 1'b1;
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_done: got done/busy activity after abort, expected none");
    end
    e = model(8, 1'b1, 8'h2E, 8'hC1);
    go8(1'b1, 8'h2E, 8'hC1);
    wait8(n, to);
    checks++;
    if (to || n != 8 || {ov8, co8, r8} !== e) begin
      errors++;
      $display("FAIL reset_fresh_op: got res=%h cout=%b ovf=%b busy=%0d timeout=%b, expected %h %b %b busy=8",
               r8, co8, ov8, n, to, e[7:0], e[8], e[9]);
    end
  endtask

  task automatic test_sweep4();
    int n; logic [9:0] e;
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          e = model(4, m[0], a, b);
          @(negedge clk);
          s4 = 1'b1; m4 = m[0]; a4 = a[3:0]; b4 = b[3:0];
          @(negedge clk);
          s4 = 1'b0;
          n = 0;
          while (done4 !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
          end
          checks++;
          if (done4 !== 1'b1 || n != 4 || {ov4, co4, r4} !== {e[9:8], e[3:0]}) begin
            errors++;
            $display("FAIL sweep4: mode %0d %0d,%0d got res=%h cout=%b ovf=%b wait=%0d, expected %h %b %b wait=4",
                     m, a, b, r4, co4, ov4, n, e[3:0], e[8], e[9]);
          end
        end
  endtask

  task automatic test_sweep2();
    int n; logic [9:0] e;
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++) begin
          e = model(2, m[0], a, b);
          @(negedge clk);
          s2 = 1'b1; m2 = m[0]; a2 = a[1:0]; b2 = b[1:0];
          @(negedge clk);
          s2 = 1'b0;
          n = 0;
          while (done2 !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
          end
          checks++;
          if (done2 !== 1'b1 || n != 2 || {ov2, co2, r2} !== {e[9:8], e[1:0]}) begin
            errors++;
            $display("FAIL sweep2: mode %0d %0d,%0d got res=%h cout=%b ovf=%b wait=%0d, expected %h %b %b wait=2",
                     m, a, b, r2, co2, ov2, n, e[1:0], e[8], e[9]);
          end
        end
  endtask

  initial begin
    s8 = 1'b0; m8 = 1'b0; a8 = '0; b8 = '0;
    s4 = 1'b0; m4 = 1'b0; a4 = '0; b4 = '0;
    s2 = 1'b0; m2 = 1'b0; a2 = '0; b2 = '0;
    test_reset();
    test_add_basic();
    test_edge_cases();
    test_random8();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep4();
    test_sweep2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
